// File: rtl/clkdiv_cfg_ctrl.sv
// Round-robin arbiter and sequencer for ratio changes on the shared clock divider.
// Grant-to-ack: 1 cycle when ratio unchanged, else 2 + low-wait + SETTLE + 2*ratio+1 cycles.
module clkdiv_cfg_ctrl #(
  parameter int N         = 4,
  parameter int NREQ      = 2,
  parameter int SETTLE    = 2,
  parameter int DEF_RATIO = 8
) (
  input  logic              i_ref_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_req_ratio,
  input  logic              i_div_clk,
  output logic [N-1:0]      o_div_ratio,
  output logic              o_clk_en,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_err,
  output logic              o_busy,
  output logic              o_locked
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = $clog2(SETTLE) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ERR, S_WAIT_LOW, S_GATE, S_LOCK, S_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, ptr_q, ptr_d, nxt_idx;
  logic [N-1:0]    ratio_q, ratio_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [N:0]      lcnt_q, lcnt_d;
  logic            from_rst_q, from_rst_d;
  logic [N-1:0]    div_ratio_q, div_ratio_d;
  logic            clk_en_q, clk_en_d;
  logic [NREQ-1:0] ack_q, ack_d, err_q, err_d;
  logic            busy_q, busy_d;
  logic            locked_q, locked_d;
  logic            found;
  int              cand;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ratio_d     = ratio_q;
    ptr_d       = ptr_q;
    gcnt_d      = gcnt_q;
    lcnt_d      = lcnt_q;
    from_rst_d  = from_rst_q;
    div_ratio_d = div_ratio_q;
    clk_en_d    = clk_en_q;
    locked_d    = locked_q;
    ack_d       = '0;
    err_d       = '0;
    found       = 1'b0;
    cand        = 0;
    nxt_idx     = (int'(idx_q) == NREQ - 1) ? '0 : IW'(idx_q + 1'b1);

    case (state_q)
      S_IDLE: begin
        // Search upward from the pointer with wrap; first set bit wins.
        for (int i = 0; i < NREQ; i++) begin
          cand = int'(ptr_q) + i;
          if (cand >= NREQ) cand = cand - NREQ;
          if (!found && i_req[cand]) begin
            found   = 1'b1;
            idx_d   = IW'(cand);
            ratio_d = i_req_ratio[cand*N +: N];
          end
        end
        if (found) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (ratio_q < N'(2)) begin
          err_d[idx_q] = 1'b1;
          state_d      = S_ERR;
        end else if (ratio_q == div_ratio_q && locked_q) begin
          ack_d[idx_q] = 1'b1;
          state_d      = S_ACK;
        end else begin
          locked_d = 1'b0;
          state_d  = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!i_div_clk) begin
          clk_en_d = 1'b0;
          gcnt_d   = '0;
          state_d  = S_GATE;
        end
      end
      S_GATE: begin
        if (gcnt_q == '0) div_ratio_d = ratio_q;
        if (int'(gcnt_q) == SETTLE - 1) begin
          clk_en_d = 1'b1;
          lcnt_d   = {ratio_q, 1'b0};
          state_d  = S_LOCK;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_LOCK: begin
        if (lcnt_q == '0) begin
          locked_d   = 1'b1;
          from_rst_d = 1'b0;
          if (from_rst_q) begin
            state_d = S_IDLE;
          end else begin
            ack_d[idx_q] = 1'b1;
            state_d      = S_ACK;
          end
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end
      S_ERR, S_ACK: begin
        ptr_d   = nxt_idx;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q     <= S_LOCK;
      idx_q       <= '0;
      ptr_q       <= '0;
      ratio_q     <= '0;
      gcnt_q      <= '0;
      lcnt_q      <= (N+1)'(2 * DEF_RATIO);
      from_rst_q  <= 1'b1;
      div_ratio_q <= N'(DEF_RATIO);
      clk_en_q    <= 1'b1;
      ack_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      ratio_q     <= ratio_d;
      gcnt_q      <= gcnt_d;
      lcnt_q      <= lcnt_d;
      from_rst_q  <= from_rst_d;
      div_ratio_q <= div_ratio_d;
      clk_en_q    <= clk_en_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
    end
  end

  assign o_div_ratio = div_ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_ack       = ack_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;
  assign o_locked    = locked_q;
endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Bench for clkdiv_cfg_ctrl: request waves scored against a service-order model,
// plus directed reset / lock-timing checks.
module tb_clkdiv_cfg_ctrl;
  localparam int N = 4, NREQ = 2, SETTLE = 2, DEF_RATIO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] req_ratio = '0;
  logic              div_clk = 1'b0;
  logic [N-1:0]      div_ratio_o;
  logic              clk_en_o;
  logic [NREQ-1:0]   ack_o, err_o;
  logic              busy_o, locked_o;

  clkdiv_cfg_ctrl #(.N(N), .NREQ(NREQ), .SETTLE(SETTLE), .DEF_RATIO(DEF_RATIO)) dut (
    .i_ref_clk(clk), .i_rst(rst), .i_req(req), .i_req_ratio(req_ratio),
    .i_div_clk(div_clk), .o_div_ratio(div_ratio_o), .o_clk_en(clk_en_o),
    .o_ack(ack_o), .o_err(err_o), .o_busy(busy_o), .o_locked(locked_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int idx;
    bit is_err;
    int ratio;
    int when;
  } exp_t;
  exp_t exp_q[$];

  // Reference state: the ratio the divider should run at and the arbitration pointer.
  int m_ratio = DEF_RATIO;
  int m_ptr   = 0;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: every ack/err pulse is matched against the next expected response.
  exp_t e_mon;
  always @(negedge clk) begin
    if ((ack_o | err_o) != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", int'({ack_o, err_o}), 0);
      end else begin
        e_mon = exp_q.pop_front();
        chk("ack_vec", int'(ack_o), e_mon.is_err ? 0 : (1 << e_mon.idx));
        chk("err_vec", int'(err_o), e_mon.is_err ? (1 << e_mon.idx) : 0);
        chk("div_ratio_at_resp", int'(div_ratio_o), e_mon.ratio);
        chk("locked_at_resp", int'(locked_o), 1);
        chk("clk_en_at_resp", int'(clk_en_o), 1);
        chk("busy_at_resp", int'(busy_o), 1);
        chk("resp_cycle", cyc, e_mon.when);
      end
    end
  end

  // Issue a set of simultaneous requests; div_clk is held high for 'hold' cycles.
  task automatic run_wave(input logic [NREQ-1:0] mask, input int r0, input int r1,
                          input int hold, output int low_cnt);
    int   rat[NREQ];
    int   t, k, lat, start_ptr, start_c;
    bit   first;
    exp_t e;
    rat[0] = r0;
    rat[1] = r1;
    for (int j = 0; j < NREQ; j++) req_ratio[j*N +: N] = N'(rat[j]);
    t = cyc + 1;
    first = 1'b1;
    start_ptr = m_ptr;
    for (int i = 0; i < NREQ; i++) begin
      k = (start_ptr + i) % NREQ;
      if (mask[k]) begin
        e.idx = k;
        e.is_err = (rat[k] < 2);
        if (rat[k] < 2 || rat[k] == m_ratio) begin
          lat = 1;
        end else begin
          lat = 2 + ((first && hold > 1) ? hold - 1 : 0) + SETTLE + 2 * rat[k] + 1;
          m_ratio = rat[k];
        end
        e.ratio = m_ratio;
        e.when = t + lat;
        exp_q.push_back(e);
        t = e.when + 2;
        m_ptr = (k + 1) % NREQ;
        first = 1'b0;
      end
    end
    div_clk = (hold > 0);
    req = mask;
    start_c = cyc;
    low_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cyc == start_c + 1 + hold) div_clk = 1'b0;
      if (!clk_en_o) low_cnt++;
      req = req & ~(ack_o | err_o);
      if (req == '0) break;
    end
    if (req != '0) begin
      chk("wave_timeout", int'(req), 0);
      req = '0;
    end
    div_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // After reset release, o_locked must rise on exactly the 17th edge.
  task automatic check_relock(input string tag);
    int c2;
    c2 = cyc;
    while (cyc < c2 + 2 * DEF_RATIO) @(negedge clk);
    chk({tag, "_locked_before"}, int'(locked_o), 0);
    chk({tag, "_busy_before"}, int'(busy_o), 1);
    @(negedge clk);
    chk({tag, "_locked_after"}, int'(locked_o), 1);
    chk({tag, "_busy_after"}, int'(busy_o), 0);
    chk({tag, "_ratio"}, int'(div_ratio_o), DEF_RATIO);
    chk({tag, "_clk_en"}, int'(clk_en_o), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, c, m, r0, r1, hold;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ratio", int'(div_ratio_o), DEF_RATIO);
    chk("rst_clk_en", int'(clk_en_o), 1);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_busy", int'(busy_o), 1);
    chk("rst_ack", int'(ack_o), 0);
    rst = 1'b0;
    check_relock("init");

    run_wave(2'b01, 8, 0, 0, low);
    chk("same_ratio_clk_en_low", low, 0);
    run_wave(2'b10, 0, 1, 0, low);
    chk("err_clk_en_low", low, 0);
    chk("err_ratio_kept", int'(div_ratio_o), 8);
    chk("err_locked_kept", int'(locked_o), 1);
    run_wave(2'b01, 4, 0, 0, low);
    chk("ratio4_clk_en_low", low, SETTLE);
    run_wave(2'b11, 6, 3, 0, low);
    run_wave(2'b11, 5, 7, 0, low);
    run_wave(2'b01, 9, 0, 4, low);
    chk("waitlow_clk_en_low", low, SETTLE);

    // Reset while the divider is gated during a change to 5.
    req_ratio[0 +: N] = N'(5);
    req = 2'b01;
    c = cyc;
    while (cyc < c + 3) @(negedge clk);
    chk("gate_clk_en", int'(clk_en_o), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ratio", int'(div_ratio_o), DEF_RATIO);
    chk("midrst_clk_en", int'(clk_en_o), 1);
    chk("midrst_locked", int'(locked_o), 0);
    chk("midrst_ack", int'(ack_o), 0);
    chk("midrst_busy", int'(busy_o), 1);
    req = '0;
    rst = 1'b0;
    m_ratio = DEF_RATIO;
    m_ptr = 0;
    check_relock("midrst");

    for (int w = 0; w < 30; w++) begin
      m = $urandom_range(1, 3);
      r0 = $urandom_range(0, 15);
      r1 = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) r0 = m_ratio;
      hold = $urandom_range(0, 4);
      run_wave(NREQ'(m), r0, r1, hold, low);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
